// File: rtl/gate_arbiter_pkg.sv
// Shared opcode encoding for the bitwise logic unit and its clients.
// Requester indices and the round-robin pointer are 3 bits wide, which caps N at 8.
package gate_arbiter_pkg;

    localparam int OPW = 3;
    localparam int IDW = 3;

    typedef logic [OPW-1:0] opcode_t;

    localparam opcode_t OP_NAND = 3'd0;
    localparam opcode_t OP_AND  = 3'd1;
    localparam opcode_t OP_OR   = 3'd2;
    localparam opcode_t OP_NOT  = 3'd3;
    localparam opcode_t OP_XOR  = 3'd4;
    localparam opcode_t OP_NOR  = 3'd5;

    function automatic logic op_illegal(input opcode_t op);
        return (op > OP_NOR);
    endfunction

endpackage

// File: rtl/gate_unit.sv
// Combinational W-bit bitwise logic unit; one gate slice per bit.
module gate_unit
    import gate_arbiter_pkg::*;
#(
    parameter int W = 16
) (
    input  opcode_t        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   out,
    output logic           err
);

    assign err = op_illegal(op);

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic r_nand, r_and, r_or, r_not, r_xor, r_nor;

        assign r_nand = ~(a[i] & b[i]);
        assign r_and  = a[i] & b[i];
        assign r_or   = a[i] | b[i];
        assign r_not  = ~a[i];
        assign r_xor  = a[i] ^ b[i];
        assign r_nor  = ~(a[i] | b[i]);

        // Illegal opcodes fall through to zero.
        assign out[i] = (op == OP_NAND) ? r_nand :
                        (op == OP_AND)  ? r_and  :
                        (op == OP_OR)   ? r_or   :
                        (op == OP_NOT)  ? r_not  :
                        (op == OP_XOR)  ? r_xor  :
                        (op == OP_NOR)  ? r_nor  : 1'b0;
    end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter sharing one gate_unit among N requesters, with a
// single-entry registered response buffer.
//
//  state | meaning
//  ------+---------------------------
//  IDLE  | response buffer empty
//  FULL  | response buffer holds a result
module gate_arbiter
    import gate_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [3*N-1:0]   op,
    input  logic [W*N-1:0]   a,
    input  logic [W*N-1:0]   b,
    output logic [N-1:0]     gnt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]      state;
    logic [IDW-1:0]  last;
    logic [IDW-1:0]  winner;
    logic            accept;

    // Lanes padded out to 8 so a 3-bit index always lands in range.
    logic [7:0]      req_pad;
    opcode_t         op_arr [8];
    logic [W-1:0]    a_arr  [8];
    logic [W-1:0]    b_arr  [8];

    for (genvar g = 0; g < 8; g++) begin : g_lane
        if (g < N) begin : g_used
            assign req_pad[g] = req[g];
            assign op_arr[g]  = op[3*g +: 3];
            assign a_arr[g]   = a[W*g +: W];
            assign b_arr[g]   = b[W*g +: W];
        end else begin : g_pad
            assign req_pad[g] = 1'b0;
            assign op_arr[g]  = OP_NAND;
            assign a_arr[g]   = '0;
            assign b_arr[g]   = '0;
        end
    end

    assign rsp_valid = (state == ST_FULL);
    assign accept    = ((state == ST_IDLE) || (rsp_valid && rsp_ready)) && (|req);

    // First asserted request after the last winner, wrapping modulo N.
    always_comb begin
        logic [3:0]     pos;
        logic           found;
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 1; k <= N; k++) begin
            pos = {1'b0, last} + 4'(k);
            if (pos >= 4'(N)) begin
                pos = pos - 4'(N);
            end
            if (!found && req_pad[pos[2:0]]) begin
                winner = pos[2:0];
                found  = 1'b1;
            end
        end
    end

    logic [W-1:0] unit_out;
    logic         unit_err;

    gate_unit #(.W(W)) u_gate_unit (
        .op  (op_arr[winner]),
        .a   (a_arr[winner]),
        .b   (b_arr[winner]),
        .out (unit_out),
        .err (unit_err)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            last     <= IDW'(N-1);
            gnt      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            gnt <= '0;
            if (accept) begin
                gnt      <= {{(N-1){1'b0}}, 1'b1} << winner;
                rsp_id   <= winner;
                rsp_data <= unit_out;
                rsp_err  <= unit_err;
                last     <= winner;
                state    <= ST_FULL;
            end else if ((state == ST_FULL) && rsp_ready) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule
